avalon_rr_arbiter: RTL and testbench
====================================

Name: avalon_rr_arbiter

Overview:
Two-master to one-slave Avalon-MM arbiter with round-robin grant, burst locking and pipelined read-response routing.
- Sits between two Avalon-MM masters (e.g. a CPU port and a DMA port) and a single shared slave.
- Forwards the granted master's command and routes each readdatavalid beat back to the master that issued the read.

Parameters:
- NBDATABYTES, 2, data bytes per beat; data width DW = 8*NBDATABYTES, byteenable width = NBDATABYTES.
- NBADDRBITS, 8, address width.
- MAXPENDING, 4, depth of the outstanding-read FIFO (power of two, >= 2).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- mX_address  input  NBADDRBITS  master X address (X = 0, 1; same for all mX_ lines).
- mX_byteenable  input  NBDATABYTES  master X byte enables.
- mX_writedata  input  DW  master X write data.
- mX_read, mX_write  input  1 each  master X command strobes.
- mX_burstcount  input  8  master X burst length (0 treated as 1).
- mX_beginbursttransfer  input  1  master X burst start marker.
- mX_waitrequest  output  1  stall to master X.
- mX_readdata  output  DW  read data to master X.
- mX_readdatavalid  output  1  read beat valid to master X.
- s_address, s_byteenable, s_writedata, s_read, s_write, s_burstcount, s_beginbursttransfer  output  (widths as mX_)  to slave.
- s_waitrequest, s_readdata, s_readdatavalid  input  1/DW/1  from slave.
- err  output  1  sticky protocol error.

Behaviour:
- Reset: grant = NONE, last = 1 (master 0 has first priority), write beat counter = 0, FIFO empty, err = 0. s_read = s_write = 0; mX_waitrequest = 1; mX_readdatavalid = 0.
- States:
  - IDLE: arbitrate among masters with read|write asserted; the non-last master wins on a tie. Grant is registered, so the command reaches the slave one cycle after the request is seen.
  - GNT0 / GNT1: slave command outputs mirror the granted master combinationally. s_waitrequest is passed to the granted master; the other master sees waitrequest = 1.
- Acceptance: a transfer is accepted when (s_read|s_write) & !s_waitrequest.
- Single or read command accepted: return to IDLE and set last = granted master.
- Write burst: the first accepted beat loads counter = burstcount-1. Grant is locked until counter reaches 0 on an accepted beat, then return to IDLE. beginbursttransfer is forwarded on the first beat only.
- Read accepted: push {master_id, burstcount} into the FIFO.
- Each s_readdatavalid:
  - Route s_readdata to the master at the FIFO head; readdata to the other master is don't-care, its readdatavalid = 0.
  - Decrement the head beat count; pop when it reaches 0.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- FIFO full: a granted read is not forwarded (s_read = 0) and the master sees waitrequest = 1. Writes are still forwarded.
- Granted master drops its request before acceptance (protocol violation): set err, return to IDLE.
- s_readdatavalid with FIFO empty: set err, drop the beat.
- Simultaneous read and write from one master: set err, forward neither, grant held.
- Reset mid-burst or with reads outstanding: all state cleared immediately. Later slave readdatavalid with empty FIFO sets err.
- err stays set until rst.

Test Plan:
- Single write: m0 write addr 0x10 data 0xBEEF, s_waitrequest = 0 -> s_write = 1 one cycle after request, s_address = 0x10, m0_waitrequest low that cycle, m1_waitrequest = 1 throughout.
- Contention round-robin: m0 and m1 issue continuous single writes -> accepted order m0, m1, m0, m1. Each master's grant is separated by one IDLE cycle.
- Write burst lock: m1 burstcount = 4 with m0 also requesting, slave stalls 2 cycles mid-burst -> 4 m1 beats back-to-back (excluding stalls), m0 granted only afterwards.
- Pipelined reads: m0 read burst 2, then m1 read 1, slave returns 3 readdatavalid beats -> m0 gets beats 1–2, m1 gets beat 3. FIFO empty at end, err = 0.
- FIFO full: MAXPENDING = 4 reads outstanding with no responses -> 5th read stalled, s_read = 0. After one response pops, the 5th read is forwarded next cycle.
- Error and reset: readdatavalid with no outstanding read -> err = 1 and stays 1. rst asserted mid write burst -> next cycle all outputs at reset values, err = 0.

Source files
------------

// File: rtl/avalon_rr_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter: round-robin grant, write-burst lock,
// and a FIFO of outstanding reads that steers readdatavalid beats to their issuer.
module avalon_rr_arbiter #(
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int MAXPENDING  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NBADDRBITS-1:0]      m0_address,
  input  logic [NBDATABYTES-1:0]     m0_byteenable,
  input  logic [8*NBDATABYTES-1:0]   m0_writedata,
  input  logic                       m0_read,
  input  logic                       m0_write,
  input  logic [7:0]                 m0_burstcount,
  input  logic                       m0_beginbursttransfer,
  output logic                       m0_waitrequest,
  output logic [8*NBDATABYTES-1:0]   m0_readdata,
  output logic                       m0_readdatavalid,
  input  logic [NBADDRBITS-1:0]      m1_address,
  input  logic [NBDATABYTES-1:0]     m1_byteenable,
  input  logic [8*NBDATABYTES-1:0]   m1_writedata,
  input  logic                       m1_read,
  input  logic                       m1_write,
  input  logic [7:0]                 m1_burstcount,
  input  logic                       m1_beginbursttransfer,
  output logic                       m1_waitrequest,
  output logic [8*NBDATABYTES-1:0]   m1_readdata,
  output logic                       m1_readdatavalid,
  output logic [NBADDRBITS-1:0]      s_address,
  output logic [NBDATABYTES-1:0]     s_byteenable,
  output logic [8*NBDATABYTES-1:0]   s_writedata,
  output logic                       s_read,
  output logic                       s_write,
  output logic [7:0]                 s_burstcount,
  output logic                       s_beginbursttransfer,
  input  logic                       s_waitrequest,
  input  logic [8*NBDATABYTES-1:0]   s_readdata,
  input  logic                       s_readdatavalid,
  output logic                       err
);

  localparam int AW = $clog2(MAXPENDING);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       err_nxt;

  logic       granted, gid;
  logic       g_read, g_write, g_bbt;
  logic [7:0] g_bc, g_bc_n;
  logic       accept;

  logic       fid  [MAXPENDING];
  logic [7:0] fcnt [MAXPENDING];
  logic [AW:0] wptr, rptr;
  logic       empty, full, head_id, rd_valid, push, pop;
  logic [7:0] head_cnt;

  assign granted = (state != IDLE);
  assign gid     = (state == GNT1);

  always_comb begin
    g_read  = gid ? m1_read  : m0_read;
    g_write = gid ? m1_write : m0_write;
    g_bbt   = gid ? m1_beginbursttransfer : m0_beginbursttransfer;
    g_bc    = gid ? m1_burstcount : m0_burstcount;
    g_bc_n  = (g_bc == 8'd0) ? 8'd1 : g_bc;
  end

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head_id  = fid[rptr[AW-1:0]];
  assign head_cnt = fcnt[rptr[AW-1:0]];

  // Conflicting strobes forward nothing; reads are held back while the FIFO is full.
  assign s_read   = granted & g_read & ~g_write & ~full;
  assign s_write  = granted & g_write & ~g_read;
  assign s_address    = gid ? m1_address    : m0_address;
  assign s_byteenable = gid ? m1_byteenable : m0_byteenable;
  assign s_writedata  = gid ? m1_writedata  : m0_writedata;
  assign s_burstcount = g_bc;
  assign s_beginbursttransfer = granted & g_bbt & (wcnt == 8'd0);

  assign accept = (s_read | s_write) & ~s_waitrequest;
  assign m0_waitrequest = ~((state == GNT0) & accept);
  assign m1_waitrequest = ~((state == GNT1) & accept);

  assign rd_valid = s_readdatavalid & ~empty;
  assign push     = s_read & ~s_waitrequest;
  assign pop      = rd_valid & (head_cnt == 8'd1);

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = rd_valid & ~head_id;
  assign m1_readdatavalid = rd_valid & head_id;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    wcnt_nxt  = wcnt;
    err_nxt   = err;
    if (s_readdatavalid && empty)
      err_nxt = 1'b1;
    case (state)
      IDLE: begin
        if ((m0_read | m0_write) && (m1_read | m1_write))
          state_nxt = last ? GNT0 : GNT1;
        else if (m0_read | m0_write)
          state_nxt = GNT0;
        else if (m1_read | m1_write)
          state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (!(g_read | g_write)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
          wcnt_nxt  = '0;
        end else if (g_read && g_write) begin
          err_nxt = 1'b1;
        end else if (accept) begin
          // wcnt == 0 marks the first beat; later beats count down the remainder.
          if (s_read) begin
            state_nxt = IDLE;
            last_nxt  = gid;
          end else if (wcnt == 8'd0) begin
            if (g_bc_n == 8'd1) begin
              state_nxt = IDLE;
              last_nxt  = gid;
            end else begin
              wcnt_nxt = g_bc_n - 8'd1;
            end
          end else begin
            wcnt_nxt = wcnt - 8'd1;
            if (wcnt == 8'd1) begin
              state_nxt = IDLE;
              last_nxt  = gid;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      wcnt  <= '0;
      err   <= 1'b0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      wcnt  <= wcnt_nxt;
      err   <= err_nxt;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Push never hits a full slot and decrement never hits an empty one, so they cannot collide.
  always_ff @(posedge clk) begin
    if (push) begin
      fid[wptr[AW-1:0]]  <= gid;
      fcnt[wptr[AW-1:0]] <= g_bc_n;
    end
    if (rd_valid)
      fcnt[rptr[AW-1:0]] <= head_cnt - 8'd1;
  end

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// Directed bench for avalon_rr_arbiter: scoreboards for slave commands and routed read beats.
module tb_avalon_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  maddr [2];
  logic [1:0]  mbe   [2];
  logic [15:0] mwd   [2];
  logic        mr    [2];
  logic        mw    [2];
  logic [7:0]  mbc   [2];
  logic        mbbt  [2];
  logic        mwreq [2];
  logic [15:0] mrd   [2];
  logic        mrdv  [2];

  logic [7:0]  s_address;
  logic [1:0]  s_byteenable;
  logic [15:0] s_writedata;
  logic        s_read, s_write;
  logic [7:0]  s_burstcount;
  logic        s_beginbursttransfer;
  logic        s_waitrequest;
  logic [15:0] s_readdata;
  logic        s_readdatavalid;
  logic        err;

  avalon_rr_arbiter #(.NBDATABYTES(2), .NBADDRBITS(8), .MAXPENDING(4)) dut (
    .clk(clk), .rst(rst),
    .m0_address(maddr[0]), .m0_byteenable(mbe[0]), .m0_writedata(mwd[0]),
    .m0_read(mr[0]), .m0_write(mw[0]), .m0_burstcount(mbc[0]),
    .m0_beginbursttransfer(mbbt[0]), .m0_waitrequest(mwreq[0]),
    .m0_readdata(mrd[0]), .m0_readdatavalid(mrdv[0]),
    .m1_address(maddr[1]), .m1_byteenable(mbe[1]), .m1_writedata(mwd[1]),
    .m1_read(mr[1]), .m1_write(mw[1]), .m1_burstcount(mbc[1]),
    .m1_beginbursttransfer(mbbt[1]), .m1_waitrequest(mwreq[1]),
    .m1_readdata(mrd[1]), .m1_readdatavalid(mrdv[1]),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_burstcount(s_burstcount),
    .s_beginbursttransfer(s_beginbursttransfer), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .err(err)
  );

  int vectors = 0;
  int miscompares = 0;
  int ncyc = 0;
  int acc_cnt = 0;
  int acc_cyc [$];
  logic [36:0] exp_s [$];
  logic [16:0] exp_r [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave command entry: {master, write, address, data (writes only), bbt, burstcount, byteenable}.
  function automatic logic [36:0] sent(input logic mid, input logic wr, input logic [7:0] a,
                                       input logic [15:0] d, input logic bbt, input logic [7:0] bc);
    return {mid, wr, a, d, bbt, bc, 2'b11};
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if ((s_read || s_write) && !s_waitrequest) begin
      acc_cnt++;
      acc_cyc.push_back(ncyc);
      if (exp_s.size() == 0)
        chk("slave_unexpected_cmd", {63'd0, s_write}, 64'd2);
      else
        chk("slave_cmd", {27'd0, mwreq[1] == 1'b0, s_write, s_address,
                          s_write ? s_writedata : 16'h0, s_beginbursttransfer,
                          s_burstcount, s_byteenable}, {27'd0, exp_s.pop_front()});
    end
    if (mrdv[0] || mrdv[1]) begin
      if (exp_r.size() == 0)
        chk("unexpected_rdv", {62'd0, mrdv[1], mrdv[0]}, 64'd0);
      else
        chk("read_route", {47'd0, mrdv[1], mrdv[1] ? mrd[1] : mrd[0]}, {47'd0, exp_r.pop_front()});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int m);
    int budget = 60;
    bit ok = 1'b0;
    while (!ok && budget > 0) begin
      @(negedge clk);
      if (mwreq[m] === 1'b0) ok = 1'b1;
      budget--;
      @(posedge clk);
      #1;
    end
    chk("accept_within_budget", {63'd0, ok}, 64'd1);
  endtask

  task automatic mwrite(input int m, input logic [7:0] a, input logic [15:0] d,
                        input int n, input logic [7:0] bc);
    for (int i = 0; i < n; i++) begin
      maddr[m] = a;
      mwd[m]   = d + 16'(i);
      mbc[m]   = bc;
      mbbt[m]  = (n > 1);
      mw[m]    = 1'b1;
      wait_accept(m);
    end
    mw[m]   = 1'b0;
    mbbt[m] = 1'b0;
  endtask

  task automatic mread(input int m, input logic [7:0] a, input logic [7:0] bc);
    maddr[m] = a;
    mbc[m]   = bc;
    mr[m]    = 1'b1;
    wait_accept(m);
    mr[m]    = 1'b0;
  endtask

  task automatic sresp(input logic [15:0] d);
    s_readdata      = d;
    s_readdatavalid = 1'b1;
    tick();
    s_readdatavalid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_read"},  {63'd0, s_read},   64'd0);
    chk({tag, "_s_write"}, {63'd0, s_write},  64'd0);
    chk({tag, "_m0_wreq"}, {63'd0, mwreq[0]}, 64'd1);
    chk({tag, "_m1_wreq"}, {63'd0, mwreq[1]}, 64'd1);
    chk({tag, "_m0_rdv"},  {63'd0, mrdv[0]},  64'd0);
    chk({tag, "_m1_rdv"},  {63'd0, mrdv[1]},  64'd0);
    chk({tag, "_err"},     {63'd0, err},      64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1;
    s_waitrequest = 1'b0;
    s_readdata = '0;
    s_readdatavalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      maddr[i] = '0; mbe[i] = 2'b11; mwd[i] = '0; mr[i] = 1'b0;
      mw[i] = 1'b0; mbc[i] = 8'd1; mbbt[i] = 1'b0;
    end
    tick(); tick();
    @(negedge clk);
    chk_reset_outputs("reset");
    tick();
    rst = 1'b0;

    // Single write: command reaches the slave one cycle after the request.
    exp_s.push_back(sent(0, 1, 8'h10, 16'hBEEF, 0, 8'd1));
    maddr[0] = 8'h10; mwd[0] = 16'hBEEF; mbc[0] = 8'd1; mw[0] = 1'b1;
    @(negedge clk);
    chk("single_req_cycle_s_write", {63'd0, s_write}, 64'd0);
    chk("single_req_cycle_m1_wreq", {63'd0, mwreq[1]}, 64'd1);
    tick();
    @(negedge clk);
    chk("single_s_write",   {63'd0, s_write},   64'd1);
    chk("single_s_address", {56'd0, s_address}, 64'h10);
    chk("single_m0_wreq",   {63'd0, mwreq[0]},  64'd0);
    chk("single_m1_wreq",   {63'd0, mwreq[1]},  64'd1);
    tick();
    mw[0] = 1'b0;
    @(negedge clk);
    chk("single_after_s_write", {63'd0, s_write}, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Contention: alternate grants, m1 uses burstcount 0 (treated as a single beat).
    base = acc_cyc.size();
    exp_s.push_back(sent(0, 1, 8'h30, 16'h0001, 0, 8'd1));
    exp_s.push_back(sent(1, 1, 8'h40, 16'h1001, 0, 8'd0));
    exp_s.push_back(sent(0, 1, 8'h31, 16'h0002, 0, 8'd1));
    exp_s.push_back(sent(1, 1, 8'h41, 16'h1002, 0, 8'd0));
    fork
      begin mwrite(0, 8'h30, 16'h0001, 1, 8'd1); mwrite(0, 8'h31, 16'h0002, 1, 8'd1); end
      begin mwrite(1, 8'h40, 16'h1001, 1, 8'd0); mwrite(1, 8'h41, 16'h1002, 1, 8'd0); end
    join
    for (int k = 0; k < 3; k++)
      chk("rr_accept_spacing", 64'(acc_cyc[base+k+1] - acc_cyc[base+k]), 64'd2);

    // Burst lock: m1 burst of 4 with a 2-cycle slave stall; m0 waits until it ends.
    base = acc_cnt;
    exp_s.push_back(sent(1, 1, 8'h50, 16'h2000, 1, 8'd4));
    exp_s.push_back(sent(1, 1, 8'h50, 16'h2001, 0, 8'd4));
    exp_s.push_back(sent(1, 1, 8'h50, 16'h2002, 0, 8'd4));
    exp_s.push_back(sent(1, 1, 8'h50, 16'h2003, 0, 8'd4));
    exp_s.push_back(sent(0, 1, 8'h60, 16'h3000, 0, 8'd1));
    fork
      mwrite(1, 8'h50, 16'h2000, 4, 8'd4);
      begin tick(); mwrite(0, 8'h60, 16'h3000, 1, 8'd1); end
      begin
        int b = 50;
        while (acc_cnt < base + 2 && b > 0) begin @(posedge clk); b--; end
        #1;
        s_waitrequest = 1'b1;
        tick();
        @(negedge clk);
        chk("stall_m0_wreq", {63'd0, mwreq[0]}, 64'd1);
        tick();
        s_waitrequest = 1'b0;
      end
    join

    // Pipelined reads: m0 burst of 2, then m1 single; responses routed in issue order.
    exp_s.push_back(sent(0, 0, 8'h20, 16'h0, 0, 8'd2));
    exp_s.push_back(sent(1, 0, 8'h28, 16'h0, 0, 8'd1));
    mread(0, 8'h20, 8'd2);
    mread(1, 8'h28, 8'd1);
    exp_r.push_back({1'b0, 16'hA001});
    exp_r.push_back({1'b0, 16'hA002});
    exp_r.push_back({1'b1, 16'hA003});
    sresp(16'hA001); sresp(16'hA002); sresp(16'hA003);
    @(negedge clk);
    chk("reads_err", {63'd0, err}, 64'd0);
    chk("reads_all_routed", 64'(exp_r.size()), 64'd0);
    tick();

    // FIFO full: four outstanding reads, the fifth waits for one response.
    for (int i = 0; i < 4; i++) begin
      exp_s.push_back(sent(0, 0, 8'h70 + 8'(i), 16'h0, 0, 8'd1));
      mread(0, 8'h70 + 8'(i), 8'd1);
    end
    exp_s.push_back(sent(0, 0, 8'h74, 16'h0, 0, 8'd1));
    maddr[0] = 8'h74; mbc[0] = 8'd1; mr[0] = 1'b1;
    tick();
    @(negedge clk);
    chk("full_s_read_0", {63'd0, s_read}, 64'd0);
    chk("full_m0_wreq_0", {63'd0, mwreq[0]}, 64'd1);
    tick();
    @(negedge clk);
    chk("full_s_read_1", {63'd0, s_read}, 64'd0);
    tick();
    exp_r.push_back({1'b0, 16'hC000});
    s_readdata = 16'hC000;
    s_readdatavalid = 1'b1;
    @(negedge clk);
    chk("full_pop_cycle_s_read", {63'd0, s_read}, 64'd0);
    tick();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    chk("after_pop_s_read", {63'd0, s_read}, 64'd1);
    chk("after_pop_m0_wreq", {63'd0, mwreq[0]}, 64'd0);
    tick();
    mr[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_r.push_back({1'b0, 16'hC000 + 16'(i)});
      sresp(16'hC000 + 16'(i));
    end

    // Response with nothing outstanding: beat dropped, err sticky.
    @(negedge clk);
    chk("pre_err", {63'd0, err}, 64'd0);
    tick();
    sresp(16'hDEAD);
    @(negedge clk);
    chk("err_set", {63'd0, err}, 64'd1);
    tick(); tick(); tick();
    @(negedge clk);
    chk("err_sticky", {63'd0, err}, 64'd1);
    tick();

    // Reset in the middle of an m1 write burst.
    exp_s.push_back(sent(1, 1, 8'h80, 16'h4000, 1, 8'd4));
    exp_s.push_back(sent(1, 1, 8'h80, 16'h4001, 0, 8'd4));
    maddr[1] = 8'h80; mwd[1] = 16'h4000; mbc[1] = 8'd4; mbbt[1] = 1'b1; mw[1] = 1'b1;
    tick();
    tick();
    mwd[1] = 16'h4001;
    tick();
    mw[1] = 1'b0; mbbt[1] = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midburst_rst");
    tick();
    exp_s.push_back(sent(1, 1, 8'h90, 16'h5000, 0, 8'd1));
    exp_s.push_back(sent(0, 1, 8'hA0, 16'h6000, 0, 8'd1));
    mwrite(1, 8'h90, 16'h5000, 1, 8'd1);
    mwrite(0, 8'hA0, 16'h6000, 1, 8'd1);
    sresp(16'hBAD0);
    @(negedge clk);
    chk("late_rdv_err", {63'd0, err}, 64'd1);
    chk("slave_queue_drained", 64'(exp_s.size()), 64'd0);
    chk("read_queue_drained", 64'(exp_r.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
